// File: rtl/z80_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : z80_mem_responder
// Purpose  : z80 bus responder driving an async 8-bit SRAM, with HOLD stalls
//            and a one-entry last-read buffer for stall-free repeated reads.
// Revision : 1.0
// ============================================================================
module z80_mem_responder #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter bit BUF_EN  = 1'b1
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [15:0] A,
    input  logic [7:0]  CPU_DO,
    input  logic        W,
    output logic [7:0]  DI,
    output logic        HOLD,
    output logic [15:0] MEM_A,
    output logic [7:0]  MEM_D_OUT,
    input  logic [7:0]  MEM_D_IN,
    output logic        MEM_DQ_OE,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N
);

    localparam logic [3:0] C_RD_WAIT = 4'(RD_WAIT);
    localparam logic [3:0] C_WR_WAIT = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  di_q;
    logic        hold_q;
    logic [15:0] mem_a_q;
    logic [7:0]  mem_d_out_q;
    logic        dq_oe_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        buf_valid_q;
    logic [15:0] buf_addr_q;
    logic [7:0]  buf_data_q;

    logic        buf_match;
    logic        buf_hit;

    assign buf_match = buf_valid_q && (A == buf_addr_q);
    assign buf_hit   = BUF_EN && buf_match;

    // Async reset drops both strobes and the DQ drive the instant RESET_N falls.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            di_q        <= 8'h00;
            hold_q      <= 1'b1;
            mem_a_q     <= 16'h0000;
            mem_d_out_q <= 8'h00;
            dq_oe_q     <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 16'h0000;
            buf_data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_q) begin
                        if (W) begin
                            mem_a_q     <= A;
                            mem_d_out_q <= CPU_DO;
                            dq_oe_q     <= 1'b1;
                            we_n_q      <= 1'b0;
                            hold_q      <= 1'b0;
                            cnt_q       <= C_WR_WAIT;
                            state_q     <= ST_WRITE;
                            // Write-through keeps the buffered copy coherent.
                            if (buf_match) begin
                                buf_data_q <= CPU_DO;
                            end
                        end else if (buf_hit) begin
                            di_q <= buf_data_q;
                        end else begin
                            mem_a_q <= A;
                            oe_n_q  <= 1'b0;
                            hold_q  <= 1'b0;
                            cnt_q   <= C_RD_WAIT;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt_q == 4'd0) begin
                        di_q        <= MEM_D_IN;
                        buf_addr_q  <= mem_a_q;
                        buf_data_q  <= MEM_D_IN;
                        buf_valid_q <= BUF_EN;
                        oe_n_q      <= 1'b1;
                        hold_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == 4'd0) begin
                        we_n_q  <= 1'b1;
                        state_q <= ST_RECOVER;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    dq_oe_q <= 1'b0;
                    hold_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign DI        = di_q;
    assign HOLD      = hold_q;
    assign MEM_A     = mem_a_q;
    assign MEM_D_OUT = mem_d_out_q;
    assign MEM_DQ_OE = dq_oe_q;
    assign MEM_OE_N  = oe_n_q;
    assign MEM_WE_N  = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_z80_mem_responder
// Purpose  : Scoreboard bench for z80_mem_responder (buffered and unbuffered).
// Revision : 1.0
// ============================================================================
module tb_z80_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        preload;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_w;

    logic [7:0]  di_a, mdo_a, mdi_a, di_b, mdo_b, mdi_b;
    logic [15:0] ma_a, ma_b;
    logic        hold_a, dqoe_a, oen_a, wen_a, hold_b, dqoe_b, oen_b, wen_b;

    logic [7:0]  di, mdo;
    logic [15:0] ma;
    logic        hold, dqoe, oen, wen;

    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];

    always #5 clk = ~clk;

    z80_mem_responder #(.RD_WAIT(1), .WR_WAIT(1), .BUF_EN(1'b1)) u_dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .A(cpu_a), .CPU_DO(cpu_do), .W(cpu_w),
        .DI(di_a), .HOLD(hold_a), .MEM_A(ma_a), .MEM_D_OUT(mdo_a),
        .MEM_D_IN(mdi_a), .MEM_DQ_OE(dqoe_a), .MEM_OE_N(oen_a), .MEM_WE_N(wen_a)
    );

    z80_mem_responder #(.RD_WAIT(0), .WR_WAIT(0), .BUF_EN(1'b0)) u_dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .A(cpu_a), .CPU_DO(cpu_do), .W(cpu_w),
        .DI(di_b), .HOLD(hold_b), .MEM_A(ma_b), .MEM_D_OUT(mdo_b),
        .MEM_D_IN(mdi_b), .MEM_DQ_OE(dqoe_b), .MEM_OE_N(oen_b), .MEM_WE_N(wen_b)
    );

    // SRAM models: data only appears while OE_N is low, writes land while WE_N is low.
    assign mdi_a = !oen_a ? mem_a[ma_a] : 8'hEE;
    assign mdi_b = !oen_b ? mem_b[ma_b] : 8'hEE;

    always @(posedge clk) begin
        if (preload) begin
            mem_a[16'h1234] <= 8'hA5;
            mem_b[16'h0001] <= 8'h3C;
        end else begin
            if (!wen_a) mem_a[ma_a] <= mdo_a;
            if (!wen_b) mem_b[ma_b] <= mdo_b;
        end
    end

    assign di   = sel ? di_b   : di_a;
    assign hold = sel ? hold_b : hold_a;
    assign ma   = sel ? ma_b   : ma_a;
    assign mdo  = sel ? mdo_b  : mdo_a;
    assign dqoe = sel ? dqoe_b : dqoe_a;
    assign oen  = sel ? oen_b  : oen_a;
    assign wen  = sel ? wen_b  : wen_a;

    typedef struct {
        bit          abort;
        logic [7:0]  di;
        int          hold_low;
        int          oe_low;
        int          we_low;
        int          dq_hi;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    bit          inflight  = 1'b0;
    bit          prev_hold = 1'b1;
    bit          overlap;
    int          c_hold, c_oe, c_we, c_dq;
    logic [15:0] cap_a;
    logic [7:0]  cap_d;
    exp_t        cur;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                if (inflight) begin
                    cur = q.pop_front();
                    chk("abort_flag", 32'(cur.abort), 32'd1);
                    chk("abort_di", 32'(di), 32'(cur.di));
                    chk("abort_hold", 32'(hold), 32'd1);
                    chk("abort_we_n", 32'(wen), 32'd1);
                    chk("abort_dq_oe", 32'(dqoe), 32'd0);
                end
                inflight  = 1'b0;
                prev_hold = hold;
            end else begin
                if (prev_hold && !inflight && q.size() > 0) begin
                    inflight = 1'b1;
                    overlap  = 1'b0;
                    c_hold = 0; c_oe = 0; c_we = 0; c_dq = 0;
                    cap_a = 16'hxxxx; cap_d = 8'hxx;
                end
                if (inflight) begin
                    if (!oen) begin c_oe++; cap_a = ma; end
                    if (!wen) begin c_we++; cap_a = ma; cap_d = mdo; end
                    if (dqoe) c_dq++;
                    if ((!oen && !wen) || (dqoe && !oen)) overlap = 1'b1;
                    if (!hold) begin
                        c_hold++;
                    end else begin
                        cur = q.pop_front();
                        inflight = 1'b0;
                        chk("abort_flag", 32'(cur.abort), 32'd0);
                        chk("di", 32'(di), 32'(cur.di));
                        chk("hold_low_cycles", 32'(c_hold), 32'(cur.hold_low));
                        chk("oe_n_low_cycles", 32'(c_oe), 32'(cur.oe_low));
                        chk("we_n_low_cycles", 32'(c_we), 32'(cur.we_low));
                        chk("dq_oe_cycles", 32'(c_dq), 32'(cur.dq_hi));
                        chk("strobe_overlap", 32'(overlap), 32'd0);
                        if (cur.oe_low > 0 || cur.we_low > 0) chk("mem_a", 32'(cap_a), 32'(cur.addr));
                        if (cur.we_low > 0) chk("mem_d_out", 32'(cap_d), 32'(cur.wdata));
                    end
                end
                prev_hold = hold;
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic drive(input bit wr, input logic [15:0] addr, input logic [7:0] d,
                         input logic [7:0] edi, input int hl, input int oe, input int we,
                         input int dq, input bit ab);
        exp_t e;
        cpu_w  = wr;
        cpu_a  = addr;
        cpu_do = d;
        e.abort = ab; e.di = edi; e.hold_low = hl; e.oe_low = oe;
        e.we_low = we; e.dq_hi = dq; e.addr = addr; e.wdata = d;
        q.push_back(e);
    endtask

    task automatic issue(input bit wr, input logic [15:0] addr, input logic [7:0] d,
                         input logic [7:0] edi, input int hl, input int oe, input int we,
                         input int dq, input bit ab);
        int n = 0;
        @(negedge clk);
        while (!hold && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait_hold", 32'(hold), 32'd1);
        drive(wr, addr, d, edi, hl, oe, we, dq, ab);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] edi, input int hl);
        issue(1'b0, addr, 8'h00, edi, hl, hl, 0, 0, 1'b0);
    endtask

    task automatic wrt(input logic [15:0] addr, input logic [7:0] d, input logic [7:0] edi,
                       input int hl, input int we, input bit ab);
        issue(1'b1, addr, d, edi, hl, 0, we, hl, ab);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || inflight) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q.size()) + 32'(inflight), 32'd0);
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; preload = 1'b1;
        cpu_a = 16'h0000; cpu_w = 1'b0; cpu_do = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_di", 32'(di), 32'h00);
        chk("rst_hold", 32'(hold), 32'd1);
        chk("rst_mem_a", 32'(ma), 32'h0000);
        chk("rst_mem_d_out", 32'(mdo), 32'h00);
        chk("rst_dq_oe", 32'(dqoe), 32'd0);
        chk("rst_oe_n", 32'(oen), 32'd1);
        chk("rst_we_n", 32'(wen), 32'd1);
        preload = 1'b0;

        // Buffered responder, RD_WAIT=1, WR_WAIT=1
        drive(1'b0, 16'h1234, 8'h00, 8'hA5, 2, 2, 0, 0, 1'b0);
        rst_n = 1'b1;
        rd(16'h1234, 8'hA5, 0);
        wrt(16'h1234, 8'h5A, 8'hA5, 3, 2, 1'b0);
        rd(16'h1234, 8'h5A, 0);
        wrt(16'h0000, 8'h11, 8'h5A, 3, 2, 1'b0);
        rd(16'h1234, 8'h5A, 0);
        wrt(16'h0002, 8'h33, 8'h00, 0, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("second_pulse_we_n", 32'(wen), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_we_n", 32'(wen), 32'd1);
        chk("async_dq_oe", 32'(dqoe), 32'd0);
        chk("async_hold", 32'(hold), 32'd1);
        chk("async_oe_n", 32'(oen), 32'd1);
        @(negedge clk);
        drive(1'b0, 16'h1234, 8'h00, 8'h5A, 2, 2, 0, 0, 1'b0);
        rst_n = 1'b1;
        rd(16'h0000, 8'h11, 2);
        rd(16'h1234, 8'h5A, 2);
        drain();

        // Unbuffered responder, RD_WAIT=0, WR_WAIT=0
        @(negedge clk);
        rst_n = 1'b0;
        sel   = 1'b1;
        cpu_w = 1'b0;
        @(negedge clk);
        chk("b_rst_di", 32'(di), 32'h00);
        chk("b_rst_hold", 32'(hold), 32'd1);
        chk("b_rst_oe_n", 32'(oen), 32'd1);
        @(negedge clk);
        drive(1'b0, 16'h0001, 8'h00, 8'h3C, 1, 1, 0, 0, 1'b0);
        rst_n = 1'b1;
        rd(16'h0001, 8'h3C, 1);
        wrt(16'h0010, 8'hC3, 8'h3C, 2, 1, 1'b0);
        rd(16'h0010, 8'hC3, 1);
        rd(16'h0001, 8'h3C, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
